// File: rtl/run_segment_tracker_pkg.sv
// run_segment_tracker_pkg
// Shared definitions for the JPEG-LS run-mode length coder:
//   - default widths (run counter, RUNindex, J) and RUNindex saturation value
//   - event type encodings placed on ev_type (SEG / EOL / INT)
//   - FSM state encodings (IDLE / RUN)
//   - j_of_index(): the constant RUNindex -> J table
package run_segment_tracker_pkg;

  localparam int RUNCNT_W_DEF = 16;
  localparam int RI_W_DEF     = 5;
  localparam int J_W_DEF      = 4;
  localparam int RI_MAX_DEF   = 31;

  // SEG and EOL both put a '1' in the bitstream; INT puts a '0' followed by J bits of ev_rem.
  typedef enum logic [1:0] {
    EV_SEG = 2'd0,
    EV_EOL = 2'd1,
    EV_INT = 2'd2
  } ev_type_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Run-length order J for each RUNindex; a full segment is 2**J run pixels.
  function automatic logic [3:0] j_of_index(input logic [4:0] ri);
    logic [3:0] j;
    case (ri)
      5'd0,  5'd1,  5'd2,  5'd3:  j = 4'd0;
      5'd4,  5'd5,  5'd6,  5'd7:  j = 4'd1;
      5'd8,  5'd9,  5'd10, 5'd11: j = 4'd2;
      5'd12, 5'd13, 5'd14, 5'd15: j = 4'd3;
      5'd16, 5'd17:               j = 4'd4;
      5'd18, 5'd19:               j = 4'd5;
      5'd20, 5'd21:               j = 4'd6;
      5'd22, 5'd23:               j = 4'd7;
      5'd24:                      j = 4'd8;
      5'd25:                      j = 4'd9;
      5'd26:                      j = 4'd10;
      5'd27:                      j = 4'd11;
      5'd28:                      j = 4'd12;
      5'd29:                      j = 4'd13;
      5'd30:                      j = 4'd14;
      5'd31:                      j = 4'd15;
      default:                    j = 4'd0;
    endcase
    return j;
  endfunction

endpackage

// File: rtl/run_segment_tracker_if.sv
// run_segment_tracker_if
// Bundles the pixel-event input channel and the run-event output channel.
//   pixel channel : in_valid, in_ready, in_run, in_eol
//   event channel : ev_valid, ev_ready, ev_type, ev_j, ev_rem
//   status        : run_index, run_active
// Modports: slave = the tracker itself, master = the environment around it.
interface run_segment_tracker_if #(
  parameter int RUNCNT_W = 16,
  parameter int RI_W     = 5,
  parameter int J_W      = 4
) ();
  import run_segment_tracker_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_run;
  logic                in_eol;
  logic                ev_valid;
  logic                ev_ready;
  ev_type_e            ev_type;
  logic [J_W-1:0]      ev_j;
  logic [RUNCNT_W-1:0] ev_rem;
  logic [RI_W-1:0]     run_index;
  logic                run_active;

  modport slave (
    input  in_valid, in_run, in_eol, ev_ready,
    output in_ready, ev_valid, ev_type, ev_j, ev_rem, run_index, run_active
  );

  modport master (
    output in_valid, in_run, in_eol, ev_ready,
    input  in_ready, ev_valid, ev_type, ev_j, ev_rem, run_index, run_active
  );

endinterface

// File: rtl/run_segment_tracker_j_lut.sv
// run_j_lut
// Pure ROM mapping the current RUNindex to its run order J.
//   ri : RUNindex in
//   j  : J[ri] out
module run_j_lut #(
  parameter int RI_W = 5,
  parameter int J_W  = 4
) (
  input  logic [RI_W-1:0] ri,
  output logic [J_W-1:0]  j
);
  import run_segment_tracker_pkg::*;

  assign j = J_W'(j_of_index(5'(ri)));

endmodule

// File: rtl/run_segment_tracker.sv
// run_segment_tracker
// JPEG-LS run-mode length coder stage between mode decision and the Golomb/bit packer.
// Counts run pixels, emits a SEG event for every completed 2**J segment, an EOL event
// for a partial run closed by end of line, and an INT event (with the remainder count)
// when a run is interrupted. Maintains RUNindex across runs. One registered event slot,
// back-pressured through in_ready = !ev_valid || ev_ready.
// Ports:
//   clk, reset (async, active low)
//   bus        : run_segment_tracker_if.slave (pixel in, event out, run_index, run_active)
//   run_total, seg_count : only when RUN_SEG_STATS_EN is defined
module run_segment_tracker #(
  parameter int RUNCNT_W = 16,
  parameter int RI_W     = 5,
  parameter int J_W      = 4,
  parameter int RI_MAX   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  run_segment_tracker_if.slave  bus
`ifdef RUN_SEG_STATS_EN
  ,
  output logic [RUNCNT_W+8-1:0] run_total,
  output logic [7:0]            seg_count
`endif
);
  import run_segment_tracker_pkg::*;

  state_e              state_q, state_d;
  logic [RUNCNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [RI_W-1:0]     ri_q, ri_d;
  logic                ev_valid_q, ev_valid_d;
  ev_type_e            ev_type_q, ev_type_d;
  logic [J_W-1:0]      ev_j_q, ev_j_d;
  logic [RUNCNT_W-1:0] ev_rem_q, ev_rem_d;

  logic                in_ready_s;
  logic                accept_s;
  logic [J_W-1:0]      j_cur_s;
  logic [RUNCNT_W-1:0] cnt_inc_s;
  logic [RUNCNT_W-1:0] seg_len_s;
  logic                seg_hit_s;
  logic [RI_W-1:0]     ri_up_s;
  logic [RI_W-1:0]     ri_dn_s;
  logic                close_s;
  logic                seg_fire_s;
  logic                run_px_s;

  run_j_lut #(
    .RI_W (RI_W),
    .J_W  (J_W)
  ) u_j_lut (
    .ri (ri_q),
    .j  (j_cur_s)
  );

  assign in_ready_s = !ev_valid_q || bus.ev_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign cnt_inc_s  = run_cnt_q + RUNCNT_W'(1);
  assign seg_len_s  = RUNCNT_W'(1) << j_cur_s;
  assign seg_hit_s  = (cnt_inc_s == seg_len_s);
  assign ri_up_s    = (ri_q >= RI_W'(RI_MAX)) ? RI_W'(RI_MAX) : (ri_q + RI_W'(1));
  assign ri_dn_s    = (ri_q == RI_W'(0)) ? RI_W'(0) : (ri_q - RI_W'(1));

  assign bus.in_ready   = in_ready_s;
  assign bus.ev_valid   = ev_valid_q;
  assign bus.ev_type    = ev_type_q;
  assign bus.ev_j       = ev_j_q;
  assign bus.ev_rem     = ev_rem_q;
  assign bus.run_index  = ri_q;
  assign bus.run_active = (state_q == ST_RUN);

  // Next-state / event formation for one accepted pixel; ev_j always uses J before the RI update.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    ri_d       = ri_q;
    ev_valid_d = ev_valid_q;
    ev_type_d  = ev_type_q;
    ev_j_d     = ev_j_q;
    ev_rem_d   = ev_rem_q;
    close_s    = 1'b0;
    seg_fire_s = 1'b0;
    run_px_s   = 1'b0;

    if (accept_s) begin
      ev_valid_d = 1'b1;
      ev_j_d     = j_cur_s;
      ev_rem_d   = RUNCNT_W'(0);
      if (bus.in_run) begin
        run_px_s = 1'b1;
        if (seg_hit_s) begin
          // A segment completing on the EOL pixel leaves nothing over, so no EOL event follows.
          ev_type_d  = EV_SEG;
          seg_fire_s = 1'b1;
          run_cnt_d  = RUNCNT_W'(0);
          ri_d       = ri_up_s;
          if (bus.in_eol) begin
            close_s = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end else if (bus.in_eol) begin
          // cnt_inc_s is at least 1 here, so a partial run is always pending.
          ev_type_d = EV_EOL;
          run_cnt_d = RUNCNT_W'(0);
          close_s   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ev_valid_d = 1'b0;
          ev_type_d  = EV_SEG;
          ev_j_d     = J_W'(0);
          run_cnt_d  = cnt_inc_s;
          state_d    = ST_RUN;
        end
      end else begin
        ev_type_d = EV_INT;
        ev_rem_d  = run_cnt_q;
        run_cnt_d = RUNCNT_W'(0);
        ri_d      = ri_dn_s;
        close_s   = 1'b1;
        state_d   = ST_IDLE;
      end
    end else if (ev_valid_q && bus.ev_ready) begin
      ev_valid_d = 1'b0;
      ev_type_d  = EV_SEG;
      ev_j_d     = J_W'(0);
      ev_rem_d   = RUNCNT_W'(0);
    end else begin
      ev_valid_d = ev_valid_q;
    end
  end

  // State, counters and the single event slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= RUNCNT_W'(0);
      ri_q       <= RI_W'(0);
      ev_valid_q <= 1'b0;
      ev_type_q  <= EV_SEG;
      ev_j_q     <= J_W'(0);
      ev_rem_q   <= RUNCNT_W'(0);
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      ri_q       <= ri_d;
      ev_valid_q <= ev_valid_d;
      ev_type_q  <= ev_type_d;
      ev_j_q     <= ev_j_d;
      ev_rem_q   <= ev_rem_d;
    end
  end

`ifdef RUN_SEG_STATS_EN
  logic [RUNCNT_W+8-1:0] run_total_q, run_total_d;
  logic [7:0]            seg_count_q, seg_count_d;

  // Per-run statistics, cleared once the closing event has been formed.
  always_comb begin
    run_total_d = run_total_q;
    seg_count_d = seg_count_q;
    if (close_s) begin
      run_total_d = (RUNCNT_W+8)'(0);
      seg_count_d = 8'd0;
    end else if (run_px_s) begin
      run_total_d = run_total_q + (RUNCNT_W+8)'(1);
      seg_count_d = seg_fire_s ? (seg_count_q + 8'd1) : seg_count_q;
    end else begin
      run_total_d = run_total_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_total_q <= (RUNCNT_W+8)'(0);
      seg_count_q <= 8'd0;
    end else begin
      run_total_q <= run_total_d;
      seg_count_q <= seg_count_d;
    end
  end

  assign run_total = run_total_q;
  assign seg_count = seg_count_q;
`endif

endmodule

// File: tb/tb_run_segment_tracker.sv
// tb_run_segment_tracker
// Self-checking bench for run_segment_tracker: directed scenarios with literal expectations
// plus randomized pixels/back-pressure compared every cycle against a behavioural model.
// Also exercises run_total / seg_count when RUN_SEG_STATS_EN is defined.
module tb_run_segment_tracker;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  run_segment_tracker_if #(.RUNCNT_W(16), .RI_W(5), .J_W(4)) bus ();

`ifdef RUN_SEG_STATS_EN
  logic [23:0] run_total;
  logic [7:0]  seg_count;
`endif

  run_segment_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RUN_SEG_STATS_EN
    ,
    .run_total (run_total),
    .seg_count (seg_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  int jt [32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

  // behavioural model state
  int m_ri = 0, m_cnt = 0, m_active = 0, m_total = 0, m_seg = 0;
  int m_valid = 0, m_type = 0, m_j = 0, m_rem = 0;
  int acc_count = 0, issued = 0;

  typedef struct { int t; int j; int r; } ev_t;
  ev_t log_q [$];

  int rnd_ready = 0;
  int ready_val = 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ev_ready driver
  initial begin
    bus.ev_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ev_ready = (rnd_ready != 0) ? ($urandom_range(0, 99) < 70) : (ready_val != 0);
    end
  end

  // compare + model advance, once per cycle on the falling edge
  always @(negedge clk) begin : cmp
    int jm, et, er, ev, cl;
    if (!reset) begin
      m_ri = 0; m_cnt = 0; m_active = 0; m_total = 0; m_seg = 0;
      m_valid = 0; m_type = 0; m_j = 0; m_rem = 0;
      chk("rst_ev_valid", bus.ev_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_run_index", bus.run_index, 0);
      chk("rst_run_active", bus.run_active, 0);
      chk("rst_ev_type", bus.ev_type, 0);
      chk("rst_ev_j", bus.ev_j, 0);
      chk("rst_ev_rem", bus.ev_rem, 0);
    end else begin
      chk("in_ready", bus.in_ready, (m_valid == 0 || bus.ev_ready) ? 1 : 0);
      chk("ev_valid", bus.ev_valid, m_valid);
      if (m_valid != 0) begin
        chk("ev_type", bus.ev_type, m_type);
        chk("ev_j", bus.ev_j, m_j);
        chk("ev_rem", bus.ev_rem, m_rem);
      end
      chk("run_index", bus.run_index, m_ri);
      chk("run_active", bus.run_active, m_active);
`ifdef RUN_SEG_STATS_EN
      chk("run_total", run_total, m_total);
      chk("seg_count", seg_count, m_seg % 256);
`endif
      if (bus.ev_valid && bus.ev_ready) log_q.push_back('{int'(bus.ev_type), int'(bus.ev_j), int'(bus.ev_rem)});

      if (bus.in_valid && (m_valid == 0 || bus.ev_ready)) begin
        acc_count++;
        jm = jt[m_ri]; ev = 0; et = 0; er = 0; cl = 0;
        if (bus.in_run) begin
          m_total++;
          if (m_cnt + 1 == (1 << jm)) begin
            ev = 1; et = 0; m_cnt = 0; m_seg++;
            m_ri = (m_ri < 31) ? m_ri + 1 : 31;
          end else begin
            m_cnt++;
          end
          if (bus.in_eol) begin
            if (m_cnt > 0) begin ev = 1; et = 1; m_cnt = 0; end
            cl = 1;
          end
        end else begin
          ev = 1; et = 2; er = m_cnt; m_cnt = 0;
          m_ri = (m_ri > 0) ? m_ri - 1 : 0;
          cl = 1;
        end
        m_active = cl ? 0 : 1;
        if (cl) begin m_total = 0; m_seg = 0; end
        m_valid = ev;
        if (ev) begin m_type = et; m_j = jm; m_rem = er; end
      end else if (m_valid != 0 && bus.ev_ready) begin
        m_valid = 0;
      end
    end
  end

  // present one pixel and hold it until the DUT takes it
  task automatic pix(input logic run, input logic eol);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_run = run; bus.in_eol = eol;
    @(negedge clk);
    while (!bus.in_ready && n < 64) begin n++; @(negedge clk); end
    if (n >= 64) begin
      chk("pix_accept_timeout", 0, 1);
      #1 bus.in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      issued++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic exp_ev(input int idx, input int t, input int j, input int r);
    if (idx >= log_q.size()) chk($sformatf("log%0d_missing", idx), log_q.size(), idx + 1);
    else begin
      chk($sformatf("log%0d_type", idx), log_q[idx].t, t);
      chk($sformatf("log%0d_j", idx), log_q[idx].j, j);
      chk($sformatf("log%0d_rem", idx), log_q[idx].r, r);
    end
  endtask

  initial begin
    int hold_t, hold_j;
    bus.in_valid = 1'b0; bus.in_run = 1'b0; bus.in_eol = 1'b0;
    idle(3);
    reset = 1'b1;

    // S1: 5 run pixels then interruption
    log_q.delete();
    repeat (5) pix(1'b1, 1'b0);
    pix(1'b0, 1'b0);
    idle(3);
    chk("s1_log_size", log_q.size(), 5);
    for (int i = 0; i < 4; i++) exp_ev(i, 0, 0, 0);
    exp_ev(4, 2, 1, 1);
    chk("s1_run_index", bus.run_index, 3);
    chk("s1_model_ri", m_ri, 3);

    // S2: bring RI to 4, then 3 run pixels with EOL on the third
    log_q.delete();
    pix(1'b1, 1'b0);
    pix(1'b1, 1'b0); pix(1'b1, 1'b0); pix(1'b1, 1'b1);
    idle(3);
    chk("s2_log_size", log_q.size(), 3);
    exp_ev(0, 0, 0, 0);
    exp_ev(1, 0, 1, 0);
    exp_ev(2, 1, 1, 0);
    chk("s2_run_index", bus.run_index, 5);
    chk("s2_run_active", bus.run_active, 0);

    // S3: interruption at RI=0 with empty count
    do_reset();
    log_q.delete();
    pix(1'b0, 1'b1);
    idle(3);
    chk("s3_log_size", log_q.size(), 1);
    exp_ev(0, 2, 0, 0);
    chk("s3_run_index", bus.run_index, 0);

    // S4: reset mid-run at RI=8, RUNcnt=2
    repeat (14) pix(1'b1, 1'b0);
    idle(1);
    chk("s4_pre_run_index", bus.run_index, 8);
    chk("s4_model_cnt", m_cnt, 2);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("s4_rst_ev_valid", bus.ev_valid, 0);
    chk("s4_rst_run_index", bus.run_index, 0);
    chk("s4_rst_run_active", bus.run_active, 0);
    chk("s4_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1 reset = 1'b1;
    log_q.delete();
    pix(1'b1, 1'b0);
    idle(3);
    chk("s4_log_size", log_q.size(), 1);
    exp_ev(0, 0, 0, 0);
    chk("s4_post_run_index", bus.run_index, 1);

    // S5: back-pressure for 4 cycles with a pixel waiting
    ready_val = 0;
    idle(2);
    pix(1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_run = 1'b1; bus.in_eol = 1'b0;
    @(negedge clk);
    hold_t = bus.ev_type; hold_j = bus.ev_j;
    chk("s5_pending_type", hold_t, 0);
    chk("s5_pending_j", hold_j, 0);
    repeat (4) begin
      @(negedge clk);
      chk("s5_in_ready_low", bus.in_ready, 0);
      chk("s5_ev_valid_held", bus.ev_valid, 1);
      chk("s5_ev_type_held", bus.ev_type, hold_t);
      chk("s5_ev_j_held", bus.ev_j, hold_j);
    end
    ready_val = 1;
    pix(1'b1, 1'b0);
    pix(1'b1, 1'b1);
    idle(3);
    chk("s5_no_pixel_lost", acc_count, issued);

    // S6: saturate RI at 31 and run one full J=15 segment
    do_reset();
    repeat (33052) pix(1'b1, 1'b0);
    idle(2);
    chk("s6_ri_reached", bus.run_index, 31);
    log_q.delete();
    repeat (32767) pix(1'b1, 1'b0);
    idle(2);
    chk("s6_no_early_seg", log_q.size(), 0);
    pix(1'b1, 1'b0);
    idle(2);
    chk("s6_log_size", log_q.size(), 1);
    exp_ev(0, 0, 15, 0);
    chk("s6_ri_sat", bus.run_index, 31);
    chk("s6_model_cnt", m_cnt, 0);

    // S7: randomized pixels and back-pressure
    do_reset();
    rnd_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      pix($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 8);
    end
    rnd_ready = 0;
    ready_val = 1;
    idle(4);
    chk("s7_no_pixel_lost", acc_count, issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog_timeout actual=%0t required=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
